// File: rtl/uart_key_decoder.sv
// UART byte stream to game command decoder: plain keys, ANSI arrow escapes with timeout, command FIFO.
// Optional repeat filter enabled by defining UART_KEY_DECODER_REPEAT_FILTER_EN.
package enum_type;
    typedef enum logic [3:0] {
        NONE       = 4'd0,
        LEFT       = 4'd1,
        RIGHT      = 4'd2,
        DOWN       = 4'd3,
        DROP       = 4'd4,
        HOLD       = 4'd5,
        ROTATE     = 4'd6,
        ROTATE_REV = 4'd7,
        BAR        = 4'd8
    } state_type;
endpackage

module uart_key_decoder
    import enum_type::*;
#(
    parameter int ESC_TIMEOUT  = 100000,
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_TICKS = 2000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_byte,
    input  logic                 rx_error,
    input  logic                 cmd_ready,
    output logic                 cmd_valid,
    output enum_type::state_type cmd,
    output logic                 overflow,
    output logic [7:0]           drop_cnt,
    output logic                 esc_pending
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ESC  = 2'd1;
    localparam logic [1:0] ST_CSI  = 2'd2;

    localparam logic [7:0] BYTE_ESC = 8'h1B;
    localparam logic [7:0] BYTE_CSI = 8'h5B;

    localparam int TW = (ESC_TIMEOUT < 2) ? 1 : $clog2(ESC_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ESC_TIMEOUT - 1);

    localparam int PW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    // Parameter sanity: an illegal combination leaves only this empty marker block.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        ESC_TIMEOUT < 2 || REPEAT_TICKS < 1) begin : g_bad_params
    end

    function automatic state_type plain_map(input logic [7:0] b);
        case (b)
            8'h41, 8'h61: plain_map = LEFT;
            8'h44, 8'h64: plain_map = RIGHT;
            8'h53, 8'h73: plain_map = DOWN;
            8'h57, 8'h77,
            8'h20:        plain_map = DROP;
            8'h43, 8'h63: plain_map = HOLD;
            8'h58, 8'h78: plain_map = ROTATE;
            8'h5A, 8'h7A: plain_map = ROTATE_REV;
            8'h42, 8'h62: plain_map = BAR;
            default:      plain_map = NONE;
        endcase
    endfunction

    function automatic state_type arrow_map(input logic [7:0] b);
        case (b)
            8'h41:   arrow_map = ROTATE;
            8'h42:   arrow_map = DOWN;
            8'h43:   arrow_map = RIGHT;
            8'h44:   arrow_map = LEFT;
            default: arrow_map = NONE;
        endcase
    endfunction

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          dec_valid;
    state_type     dec_cmd;
    logic          dec_valid_q;
    state_type     dec_cmd_q;

    // A byte always beats the timeout; rx_error beats both and discards the byte.
    always_comb begin
        state_next = state;
        timer_next = timer;
        dec_valid  = 1'b0;
        dec_cmd    = NONE;
        if (rx_error) begin
            state_next = ST_IDLE;
            timer_next = '0;
        end else if (rx_valid) begin
            timer_next = '0;
            case (state)
                ST_IDLE: begin
                    if (rx_byte == BYTE_ESC) begin
                        state_next = ST_ESC;
                    end else begin
                        dec_cmd   = plain_map(rx_byte);
                        dec_valid = (dec_cmd != NONE);
                    end
                end
                ST_ESC: begin
                    if (rx_byte == BYTE_CSI) begin
                        state_next = ST_CSI;
                    end else if (rx_byte == BYTE_ESC) begin
                        state_next = ST_ESC;
                    end else begin
                        state_next = ST_IDLE;
                        dec_cmd    = plain_map(rx_byte);
                        dec_valid  = (dec_cmd != NONE);
                    end
                end
                ST_CSI: begin
                    if (rx_byte >= 8'h41 && rx_byte <= 8'h44) begin
                        state_next = ST_IDLE;
                        dec_cmd    = arrow_map(rx_byte);
                        dec_valid  = 1'b1;
                    end else if (rx_byte == BYTE_ESC) begin
                        state_next = ST_ESC;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (state != ST_IDLE) begin
            if (timer == TIMER_LAST) begin
                state_next = ST_IDLE;
                timer_next = '0;
            end else begin
                timer_next = timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            timer       <= '0;
            esc_pending <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_cmd_q   <= NONE;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            esc_pending <= (state_next != ST_IDLE);
            dec_valid_q <= dec_valid;
            dec_cmd_q   <= dec_cmd;
        end
    end

    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic          drop;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    state_type     mem [FIFO_DEPTH];

`ifdef UART_KEY_DECODER_REPEAT_FILTER_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    localparam logic [RW-1:0] WIN_MAX  = RW'(REPEAT_TICKS);
    localparam logic [RW-1:0] WIN_HOLD = RW'(REPEAT_TICKS - 1);

    state_type     last_cmd;
    logic [RW-1:0] win_cnt;

    // win_cnt reads k-1 for a command arriving k cycles after the last push.
    assign push_req = dec_valid_q && !((dec_cmd_q == last_cmd) && (win_cnt < WIN_HOLD));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_cmd <= NONE;
            win_cnt  <= '0;
        end else if (push_ok) begin
            last_cmd <= dec_cmd_q;
            win_cnt  <= '0;
        end else if (win_cnt != WIN_MAX) begin
            win_cnt <= win_cnt + 1'b1;
        end
    end
`else
    assign push_req = dec_valid_q;
`endif

    assign cmd_valid = (count != '0);
    assign cmd       = cmd_valid ? mem[rd_ptr] : NONE;
    assign full      = (count == FULL_COUNT);
    assign pop       = cmd_valid && cmd_ready;
    assign push_ok   = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= dec_cmd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow <= drop;
            if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule
